// File: rtl/seq_alu_pkg.sv
// Shared op and state encodings for the
// sequential ALU.
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_NAND = 2'b00,
    OP_ROL  = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_alu_alu_core.sv
// Single-cycle result and flag logic; the
// rotate value is sequenced by the top.
import seq_alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_rot,
  input  logic             i_rot_c,
  output logic [WIDTH-1:0] o_r,
  output logic             o_zero,
  output logic             o_carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_r     = '0;
    o_carry = 1'b0;
    unique case (1'b1)
      (i_op == OP_NAND): begin
        o_r = ~(i_a & i_b);
      end
      (i_op == OP_ROL): begin
        o_r     = i_rot;
        o_carry = i_rot_c;
      end
      (i_op == OP_ADD): begin
        o_r     = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
      end
      (i_op == OP_SUB): begin
        o_r     = w_dif[WIDTH-1:0];
        // top bit set means a borrow
        o_carry = ~w_dif[WIDTH];
      end
    endcase
    o_zero = (o_r == '0);
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: one op at a time, ROL
// rotates one bit per cycle.
import seq_alu_pkg::*;

module seq_alu #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH);

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_cbit;

  logic [WIDTH-1:0] w_r;
  logic             w_zero;
  logic             w_carry;
  logic             w_step;

  assign in_ready = (r_state == IDLE) && !rst;
  assign w_step   = (r_op == OP_ROL) &&
                    (r_cnt != '0);

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a     (r_work),
    .i_b     (r_b),
    .i_op    (r_op),
    .i_rot   (r_work),
    .i_rot_c (r_cbit),
    .o_r     (w_r),
    .o_zero  (w_zero),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= OP_NAND;
      r_work    <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_cbit    <= 1'b0;
      out_valid <= 1'b0;
      R         <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op    <= op_e'(OP);
            r_work  <= A;
            r_b     <= B;
            r_cnt   <= CW'(B % WIDTH);
            r_cbit  <= 1'b0;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_step) begin
            r_work <= {r_work[WIDTH-2:0],
                       r_work[WIDTH-1]};
            r_cbit <= r_work[WIDTH-1];
            r_cnt  <= r_cnt - 1'b1;
          end else begin
            R         <= w_r;
            zero      <= w_zero;
            carry     <= w_carry;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for
// seq_alu at WIDTH=7.
module tb_seq_alu;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [1:0]   OP;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] R;
  logic         zero;
  logic         carry;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the
  // negedge where out_valid is seen.
  task automatic run_op(
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output int           lat
  );
    OP = op; A = a; B = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 0",
               in_ready);
    end
    checks++;
    if ({out_valid, R, zero, carry} !== '0)
    begin
      errors++;
      $display("FAIL rst_outs got %b%b%b%b",
               out_valid, R, zero, carry);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b want 1",
               in_ready);
    end
  endtask

  task automatic test_nand();
    int lat;
    run_op(2'b00, 7'b1010101, 7'b0101010, lat);
    checks++;
    if ({R, zero, carry} !== {7'b1111111, 2'b00})
    begin
      errors++;
      $display("FAIL nand got R=%b z=%b c=%b",
               R, zero, carry);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL nand_lat got %0d want 1", lat);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
    begin
      errors++;
      $display("FAIL hs got ov=%b ir=%b want 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_rol();
    int lat;
    run_op(2'b01, 7'b1110000, 7'd3, lat);
    checks++;
    if ({R, zero, carry} !== {7'b0000111, 2'b01})
    begin
      errors++;
      $display("FAIL rol3 got R=%b z=%b c=%b",
               R, zero, carry);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL rol3_lat got %0d want 4", lat);
    end
    handshake();
    run_op(2'b01, 7'b1110000, 7'd7, lat);
    checks++;
    if ({R, zero, carry} !== {7'b1110000, 2'b00})
    begin
      errors++;
      $display("FAIL rol7 got R=%b z=%b c=%b",
               R, zero, carry);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL rol7_lat got %0d want 1", lat);
    end
    handshake();
    run_op(2'b01, 7'b0000001, 7'd0, lat);
    checks++;
    if ({R, zero, carry, lat[3:0]} !==
        {7'b0000001, 2'b00, 4'd1}) begin
      errors++;
      $display("FAIL rol0 got R=%b c=%b lat=%0d",
               R, carry, lat);
    end
    handshake();
    run_op(2'b01, 7'b1000011, 7'd1, lat);
    checks++;
    if ({R, zero, carry, lat[3:0]} !==
        {7'b0000111, 2'b01, 4'd2}) begin
      errors++;
      $display("FAIL rol1 got R=%b c=%b lat=%0d",
               R, carry, lat);
    end
    handshake();
    run_op(2'b01, 7'b0000011, 7'd8, lat);
    checks++;
    if ({R, zero, carry, lat[3:0]} !==
        {7'b0000110, 2'b00, 4'd2}) begin
      errors++;
      $display("FAIL rol8 got R=%b c=%b lat=%0d",
               R, carry, lat);
    end
    handshake();
  endtask

  task automatic test_add();
    int lat;
    run_op(2'b10, 7'b1111111, 7'b0000001, lat);
    checks++;
    if ({R, zero, carry, lat[3:0]} !==
        {7'b0000000, 2'b11, 4'd1}) begin
      errors++;
      $display("FAIL add_ovf got R=%b z=%b c=%b",
               R, zero, carry);
    end
    handshake();
    run_op(2'b10, 7'b0000011, 7'b0000100, lat);
    checks++;
    if ({R, zero, carry} !== {7'b0000111, 2'b00})
    begin
      errors++;
      $display("FAIL add got R=%b z=%b c=%b",
               R, zero, carry);
    end
    handshake();
  endtask

  task automatic test_sub();
    int lat;
    run_op(2'b11, 7'b0001111, 7'b0000100, lat);
    checks++;
    if ({R, zero, carry} !== {7'b0001011, 2'b01})
    begin
      errors++;
      $display("FAIL sub_pos got R=%b z=%b c=%b",
               R, zero, carry);
    end
    handshake();
    run_op(2'b11, 7'b0000100, 7'b0001111, lat);
    checks++;
    if ({R, zero, carry} !== {7'b1110101, 2'b00})
    begin
      errors++;
      $display("FAIL sub_neg got R=%b z=%b c=%b",
               R, zero, carry);
    end
    handshake();
    run_op(2'b11, 7'b0000101, 7'b0000101, lat);
    checks++;
    if ({R, zero, carry} !== {7'b0000000, 2'b11})
    begin
      errors++;
      $display("FAIL sub_eq got R=%b z=%b c=%b",
               R, zero, carry);
    end
    handshake();
  endtask

  task automatic test_hold();
    int lat;
    run_op(2'b10, 7'b0000011, 7'b0000100, lat);
    OP = 2'b00; A = 7'd0; B = 7'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, R, zero, carry}
          !== {2'b10, 7'b0000111, 2'b00}) begin
        errors++;
        $display("FAIL hold%0d ov=%b ir=%b R=%b",
                 i, out_valid, in_ready, R);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
    begin
      errors++;
      $display("FAIL hold_hs ov=%b ir=%b want 0 1",
               out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0)
    begin
      errors++;
      $display("FAIL pend_acc ir=%b ov=%b want 0 0",
               in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, R, zero, carry} !==
        {1'b1, 7'b1111111, 2'b00}) begin
      errors++;
      $display("FAIL pend_res ov=%b R=%b",
               out_valid, R);
    end
    handshake();
  endtask

  task automatic test_abort();
    int seen;
    OP = 2'b01; A = 7'b0000001; B = 7'd6;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_rdy got %b want 0",
               in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, R} !==
        {2'b10, 7'b0000000}) begin
      errors++;
      $display("FAIL abort ir=%b ov=%b R=%b",
               in_ready, out_valid, R);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_late got %0d want 0",
               seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    A = '0; B = '0; OP = 2'b00;
    @(negedge clk);
    test_reset();
    test_nand();
    test_rol();
    test_add();
    test_sub();
    test_hold();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
